// File: rtl/l1_trigger_wb_intercon.sv
// l1_trigger_wb_intercon: registered Wishbone classic decoder from the SURF control bus to four trigger subspaces
module l1_trigger_wb_intercon #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] GATED_DATA = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        clock_enabled_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [14:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [31:0] wb_dat_o,
  output logic        thresh_cyc_o,
  output logic        thresh_stb_o,
  output logic        thresh_we_o,
  output logic [12:0] thresh_adr_o,
  output logic [31:0] thresh_dat_o,
  output logic [3:0]  thresh_sel_o,
  input  logic        thresh_ack_i,
  input  logic        thresh_err_i,
  input  logic        thresh_rty_i,
  input  logic [31:0] thresh_dat_i,
  output logic        control_cyc_o,
  output logic        control_stb_o,
  output logic        control_we_o,
  output logic [12:0] control_adr_o,
  output logic [31:0] control_dat_o,
  output logic [3:0]  control_sel_o,
  input  logic        control_ack_i,
  input  logic        control_err_i,
  input  logic        control_rty_i,
  input  logic [31:0] control_dat_i,
  output logic        agc_cyc_o,
  output logic        agc_stb_o,
  output logic        agc_we_o,
  output logic [12:0] agc_adr_o,
  output logic [31:0] agc_dat_o,
  output logic [3:0]  agc_sel_o,
  input  logic        agc_ack_i,
  input  logic        agc_err_i,
  input  logic        agc_rty_i,
  input  logic [31:0] agc_dat_i,
  output logic        bq_cyc_o,
  output logic        bq_stb_o,
  output logic        bq_we_o,
  output logic [12:0] bq_adr_o,
  output logic [31:0] bq_dat_o,
  output logic [3:0]  bq_sel_o,
  input  logic        bq_ack_i,
  input  logic        bq_err_i,
  input  logic        bq_rty_i,
  input  logic [31:0] bq_dat_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [12:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d, rdat_q, rdat_d, s_dat;
  logic [3:0] sel_q, sel_d, cyc_q, cyc_d, acks, errs, rtys;
  logic [1:0] sp_q, sp_d;
  logic we_q, we_d, ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic req, gated, s_ack, s_err, s_rty, resp, tmo, go, fin;
  assign acks = {bq_ack_i, agc_ack_i, control_ack_i, thresh_ack_i};
  assign errs = {bq_err_i, agc_err_i, control_err_i, thresh_err_i};
  assign rtys = {bq_rty_i, agc_rty_i, control_rty_i, thresh_rty_i};
  assign s_ack = acks[sp_q];
  assign s_err = errs[sp_q];
  assign s_rty = rtys[sp_q];
  assign s_dat = sp_q == 2'd0 ? thresh_dat_i : sp_q == 2'd1 ? control_dat_i :
                 sp_q == 2'd2 ? agc_dat_i : bq_dat_i;
  assign resp = s_ack | s_err | s_rty;
  assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign req = wb_cyc_i & wb_stb_i;
  assign gated = ~wb_adr_i[14] & ~clock_enabled_i;
  assign go = state_q == IDLE && req;
  assign fin = state_q == ACCESS && (resp || tmo);
  // state and all registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      sp_q <= '0;
      cyc_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
      rdat_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      we_q <= we_d;
      sp_q <= sp_d;
      cyc_q <= cyc_d;
      ack_q <= ack_d;
      err_q <= err_d;
      rty_q <= rty_d;
      rdat_q <= rdat_d;
    end
  end
  // gated spaces skip ACCESS; a response or timeout ends ACCESS; DONE lasts one cycle
  always_comb begin
    state_d = state_q == IDLE ? (req ? (gated ? DONE : ACCESS) : IDLE) :
              state_q == ACCESS ? (fin ? DONE : ACCESS) : IDLE;
  end
  // latch the request, run the timeout, and form the next response with err > rty > ack
  always_comb begin
    adr_d = go ? wb_adr_i[12:0] : adr_q;
    dat_d = go ? wb_dat_i : dat_q;
    sel_d = go ? wb_sel_i : sel_q;
    we_d = go ? wb_we_i : we_q;
    sp_d = go ? wb_adr_i[14:13] : sp_q;
    cnt_d = state_q == ACCESS ? cnt_q + 1'b1 : '0;
    cyc_d = go && !gated ? 4'b0001 << wb_adr_i[14:13] :
            state_q == ACCESS && !fin ? cyc_q : 4'b0000;
    err_d = fin && (s_err || !resp);
    rty_d = fin && !s_err && s_rty;
    ack_d = (go && gated) || (fin && s_ack && !s_err && !s_rty);
    rdat_d = go && gated ? GATED_DATA :
             !fin ? rdat_q :
             !resp ? 32'hFFFF_FFFF :
             s_ack && !s_err && !s_rty ? s_dat : 32'h0000_0000;
  end
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = rty_q;
  assign wb_dat_o = rdat_q;
  assign {thresh_cyc_o, thresh_stb_o} = {2{cyc_q[0]}};
  assign {control_cyc_o, control_stb_o} = {2{cyc_q[1]}};
  assign {agc_cyc_o, agc_stb_o} = {2{cyc_q[2]}};
  assign {bq_cyc_o, bq_stb_o} = {2{cyc_q[3]}};
  assign {thresh_we_o, control_we_o, agc_we_o, bq_we_o} = {4{we_q}};
  assign {thresh_adr_o, control_adr_o, agc_adr_o, bq_adr_o} = {4{adr_q}};
  assign {thresh_dat_o, control_dat_o, agc_dat_o, bq_dat_o} = {4{dat_q}};
  assign {thresh_sel_o, control_sel_o, agc_sel_o, bq_sel_o} = {4{sel_q}};
endmodule

// File: tb/tb_l1_trigger_wb_intercon.sv
// tb_l1_trigger_wb_intercon: directed vector bench with a delay-programmable slave on every port
module tb_l1_trigger_wb_intercon;
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1, clock_enabled_i = 1'b0;
  logic wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [14:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0] wb_sel_i = '0;
  logic wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0] wb_dat_o;
  logic thresh_cyc_o, thresh_stb_o, thresh_we_o, thresh_ack_i, thresh_err_i, thresh_rty_i;
  logic control_cyc_o, control_stb_o, control_we_o, control_ack_i, control_err_i, control_rty_i;
  logic agc_cyc_o, agc_stb_o, agc_we_o, agc_ack_i, agc_err_i, agc_rty_i;
  logic bq_cyc_o, bq_stb_o, bq_we_o, bq_ack_i, bq_err_i, bq_rty_i;
  logic [12:0] thresh_adr_o, control_adr_o, agc_adr_o, bq_adr_o;
  logic [31:0] thresh_dat_o, control_dat_o, agc_dat_o, bq_dat_o;
  logic [31:0] thresh_dat_i, control_dat_i, agc_dat_i, bq_dat_i;
  logic [3:0] thresh_sel_o, control_sel_o, agc_sel_o, bq_sel_o;
  logic [3:0] stbv, cycv;
  logic fire, ka, ke, kr;
  int wcnt = 0, sl_delay = 0, sl_kind = 4, total = 0, bad = 0;
  logic [31:0] sl_data = '0;

  typedef struct {
    logic [14:0] adr; logic we; logic [31:0] wdat; logic [3:0] sel; logic cen;
    int dly; int kind; logic [31:0] sdat;
    int e_lat; logic [2:0] e_resp; logic [31:0] e_dat; logic [3:0] e_port; int e_stbn;
  } vec_t;
  vec_t vecs[9];

  l1_trigger_wb_intercon dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .clock_enabled_i(clock_enabled_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o),
    .thresh_cyc_o(thresh_cyc_o), .thresh_stb_o(thresh_stb_o), .thresh_we_o(thresh_we_o),
    .thresh_adr_o(thresh_adr_o), .thresh_dat_o(thresh_dat_o), .thresh_sel_o(thresh_sel_o),
    .thresh_ack_i(thresh_ack_i), .thresh_err_i(thresh_err_i), .thresh_rty_i(thresh_rty_i),
    .thresh_dat_i(thresh_dat_i),
    .control_cyc_o(control_cyc_o), .control_stb_o(control_stb_o), .control_we_o(control_we_o),
    .control_adr_o(control_adr_o), .control_dat_o(control_dat_o), .control_sel_o(control_sel_o),
    .control_ack_i(control_ack_i), .control_err_i(control_err_i), .control_rty_i(control_rty_i),
    .control_dat_i(control_dat_i),
    .agc_cyc_o(agc_cyc_o), .agc_stb_o(agc_stb_o), .agc_we_o(agc_we_o),
    .agc_adr_o(agc_adr_o), .agc_dat_o(agc_dat_o), .agc_sel_o(agc_sel_o),
    .agc_ack_i(agc_ack_i), .agc_err_i(agc_err_i), .agc_rty_i(agc_rty_i),
    .agc_dat_i(agc_dat_i),
    .bq_cyc_o(bq_cyc_o), .bq_stb_o(bq_stb_o), .bq_we_o(bq_we_o),
    .bq_adr_o(bq_adr_o), .bq_dat_o(bq_dat_o), .bq_sel_o(bq_sel_o),
    .bq_ack_i(bq_ack_i), .bq_err_i(bq_err_i), .bq_rty_i(bq_rty_i),
    .bq_dat_i(bq_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  assign stbv = {bq_stb_o, agc_stb_o, control_stb_o, thresh_stb_o};
  assign cycv = {bq_cyc_o, agc_cyc_o, control_cyc_o, thresh_cyc_o};
  assign fire = (wcnt >= sl_delay) && (sl_kind != 4);
  assign ka = fire && (sl_kind == 0 || sl_kind == 3);
  assign ke = fire && (sl_kind == 1 || sl_kind == 3);
  assign kr = fire && sl_kind == 2;
  assign {thresh_ack_i, thresh_err_i} = {stbv[0] & ka, stbv[0] & ke};
  assign {control_ack_i, control_err_i} = {stbv[1] & ka, stbv[1] & ke};
  assign {agc_ack_i, agc_err_i} = {stbv[2] & ka, stbv[2] & ke};
  assign {bq_ack_i, bq_err_i} = {stbv[3] & ka, stbv[3] & ke};
  assign thresh_rty_i = stbv[0] ? kr : |stbv;
  assign control_rty_i = stbv[1] ? kr : |stbv;
  assign agc_rty_i = stbv[2] ? kr : |stbv;
  assign bq_rty_i = stbv[3] ? kr : |stbv;
  assign thresh_dat_i = stbv[0] ? sl_data : 32'hDEAD_0000;
  assign control_dat_i = stbv[1] ? sl_data : 32'hDEAD_0001;
  assign agc_dat_i = stbv[2] ? sl_data : 32'hDEAD_0002;
  assign bq_dat_i = stbv[3] ? sl_data : 32'hDEAD_0003;

  always @(posedge wb_clk_i) wcnt <= (|stbv) ? wcnt + 1 : 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic xact(input vec_t v, input string nm);
    int lat = 0, stbn = 0;
    logic [2:0] resp = '0;
    logic [31:0] d = '0, fd = '0;
    logic [3:0] pm = '0, fs = '0;
    logic [12:0] fa = '0;
    logic fwe = 1'b0;
    @(negedge wb_clk_i);
    sl_delay = v.dly; sl_kind = v.kind; sl_data = v.sdat; clock_enabled_i = v.cen;
    wb_adr_i = v.adr; wb_we_i = v.we; wb_dat_i = v.wdat; wb_sel_i = v.sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int k = 1; k <= 400 && lat == 0; k++) begin
      @(posedge wb_clk_i); #1;
      if (|stbv) begin
        if (stbn == 0) begin
          fa = stbv[0] ? thresh_adr_o : stbv[1] ? control_adr_o : stbv[2] ? agc_adr_o : bq_adr_o;
          fd = stbv[0] ? thresh_dat_o : stbv[1] ? control_dat_o : stbv[2] ? agc_dat_o : bq_dat_o;
          fs = stbv[0] ? thresh_sel_o : stbv[1] ? control_sel_o : stbv[2] ? agc_sel_o : bq_sel_o;
          fwe = stbv[0] ? thresh_we_o : stbv[1] ? control_we_o : stbv[2] ? agc_we_o : bq_we_o;
        end
        stbn++;
        pm |= stbv | cycv;
      end
      if (wb_ack_o | wb_err_o | wb_rty_o) begin
        lat = k;
        resp = {wb_rty_o, wb_err_o, wb_ack_o};
        d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk({nm, ".latency"}, 32'(lat), 32'(v.e_lat));
    chk({nm, ".resp"}, 32'(resp), 32'(v.e_resp));
    chk({nm, ".rdata"}, d, v.e_dat);
    chk({nm, ".ports"}, 32'(pm), 32'(v.e_port));
    chk({nm, ".stb_cycles"}, 32'(stbn), 32'(v.e_stbn));
    if (v.e_stbn > 0) begin
      chk({nm, ".adr"}, 32'(fa), 32'(v.adr[12:0]));
      chk({nm, ".wdat"}, fd, v.wdat);
      chk({nm, ".sel"}, 32'(fs), 32'(v.sel));
      chk({nm, ".we"}, 32'(fwe), 32'(v.we));
    end
    @(posedge wb_clk_i); #1;
    chk({nm, ".after"}, 32'({wb_ack_o, wb_err_o, wb_rty_o, stbv, cycv}), 32'h0);
  endtask

  initial begin
    logic [2:0] seen;
    //         adr      we    wdat          sel   cen   dly kind sdat          lat  resp    e_dat         port     stbn
    vecs[0] = '{15'h4010, 1'b0, 32'h0,         4'hF, 1'b1, 0, 0, 32'h1234_5678, 2,   3'b001, 32'h1234_5678, 4'b0100, 1};
    vecs[1] = '{15'h6004, 1'b1, 32'hA5A5_A5A5, 4'hF, 1'b1, 0, 0, 32'h0,         2,   3'b001, 32'h0,         4'b1000, 1};
    vecs[2] = '{15'h2000, 1'b1, 32'h1111_2222, 4'h3, 1'b0, 0, 0, 32'h5555_5555, 1,   3'b001, 32'h0,         4'b0000, 0};
    vecs[3] = '{15'h2000, 1'b0, 32'h0,         4'hF, 1'b1, 3, 0, 32'hCAFE_BABE, 5,   3'b001, 32'hCAFE_BABE, 4'b0010, 4};
    vecs[4] = '{15'h0123, 1'b0, 32'h0,         4'h1, 1'b0, 0, 0, 32'h7777_7777, 1,   3'b001, 32'h0,         4'b0000, 0};
    vecs[5] = '{15'h1FFF, 1'b1, 32'hDEAD_BEEF, 4'h8, 1'b1, 1, 2, 32'h9999_9999, 3,   3'b100, 32'h0,         4'b0001, 2};
    vecs[6] = '{15'h5555, 1'b0, 32'h0,         4'hC, 1'b0, 0, 3, 32'h4444_4444, 2,   3'b010, 32'h0,         4'b0100, 1};
    vecs[7] = '{15'h7FFF, 1'b1, 32'h0F0F_0F0F, 4'h5, 1'b0, 2, 1, 32'h3333_3333, 4,   3'b010, 32'h0,         4'b1000, 3};
    vecs[8] = '{15'h0042, 1'b0, 32'h0,         4'hF, 1'b1, 0, 4, 32'h2222_2222, 256, 3'b010, 32'hFFFF_FFFF, 4'b0001, 255};
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("reset.resp", 32'({wb_ack_o, wb_err_o, wb_rty_o}), 32'h0);
    chk("reset.rdata", wb_dat_o, 32'h0);
    chk("reset.cyc_stb", 32'({stbv, cycv}), 32'h0);
    chk("reset.adr", 32'({thresh_adr_o, bq_adr_o}), 32'h0);
    chk("reset.dat_sel_we", agc_dat_o | 32'(control_sel_o) | 32'(agc_we_o), 32'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 9; i++) xact(vecs[i], $sformatf("vec%0d", i));
    @(negedge wb_clk_i);
    sl_kind = 4; clock_enabled_i = 1'b1; wb_adr_i = 15'h4020; wb_we_i = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_mid.pre_cyc", 32'(cycv), 32'h4);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("rst_mid.cyc", 32'({stbv, cycv}), 32'h0);
    seen = {wb_ack_o, wb_err_o, wb_rty_o};
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      seen |= {wb_ack_o, wb_err_o, wb_rty_o};
    end
    chk("rst_mid.no_resp", 32'(seen), 32'h0);
    xact(vecs[0], "post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
